// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: merges stage stalls, a fixed-latency busy timer and a branch flush; 0-cycle outputs, no backpressure.
// Optional perf counters (perf_stall_cnt, perf_flush_cnt) are built only when STALL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int NSTAGE      = 5,
    parameter int CNT_W       = 4,
    parameter int BUSY_STAGE  = 3,
    parameter int FLUSH_STAGE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              busy_start,
    input  logic [CNT_W-1:0]  busy_len,
    input  logic              flush_req,
    output logic [NSTAGE-1:0] stall_state,
    output logic [NSTAGE-1:0] flush_state,
`ifdef STALL_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt,
`endif
    output logic              ctrl_busy
);

    typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;

    logic               busy_start_ok;
    logic               busy_act;
    logic [NSTAGE-1:0]  eff;
    logic [NSTAGE-1:0]  stall_raw;
    logic [NSTAGE-1:0]  flush_mask;
    logic               above;
    logic               late_req;
    logic               blocked;
    logic               fire;

    always_comb begin
        busy_start_ok = busy_start & (busy_len != '0);
        busy_act      = busy_start_ok | (state_q == BUSY);

        eff             = stall_req;
        eff[BUSY_STAGE] = stall_req[BUSY_STAGE] | busy_act;

        // Thermometer: every register at or below the oldest requester holds.
        above     = 1'b0;
        stall_raw = '0;
        late_req  = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            above        = above | eff[k];
            stall_raw[k] = above;
            if (k > FLUSH_STAGE) begin
                late_req = late_req | eff[k];
            end
        end

        flush_mask = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (k <= FLUSH_STAGE) begin
                flush_mask[k] = 1'b1;
            end
        end

        // An older instruction still stalled must resolve before the redirect can be taken.
        blocked = late_req | (busy_act & (BUSY_STAGE >= FLUSH_STAGE));
        fire    = (flush_req | pend_q) & ~blocked & ~rst;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rst) begin
            cnt_d = '0;
        end else if (fire && (BUSY_STAGE < FLUSH_STAGE)) begin
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (busy_start_ok) begin
            cnt_d = busy_len - CNT_W'(1);
        end

        pend_d = pend_q;
        if (rst || fire) begin
            pend_d = 1'b0;
        end else if (flush_req) begin
            pend_d = 1'b1;
        end

        state_d = state_q;
        case (state_q)
            RUN:     if (cnt_d != '0) state_d = BUSY;
            BUSY:    if (cnt_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_state = '0;
        flush_state = '0;
        ctrl_busy   = 1'b0;
        if (!rst) begin
            stall_state = fire ? (stall_raw & ~flush_mask) : stall_raw;
            flush_state = fire ? flush_mask : '0;
            // A request being parked this cycle already counts as pending.
            ctrl_busy   = (state_q == BUSY) | pend_q | (flush_req & blocked);
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
    end

`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [15:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (rst) begin
            perf_stall_cnt_d = '0;
            perf_flush_cnt_d = '0;
        end else begin
            if (stall_state[0]) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
            if (fire)           perf_flush_cnt_d = perf_flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        perf_stall_cnt_q <= perf_stall_cnt_d;
        perf_flush_cnt_q <= perf_flush_cnt_d;
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors with literal expectations plus a per-cycle model compare.
module tb_pipe_hazard_ctrl;

    localparam int NS = 5;
    localparam int BS = 3;
    localparam int FS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] stall_req;
    logic          busy_start;
    logic [3:0]    busy_len;
    logic          flush_req;
    logic [NS-1:0] stall_state;
    logic [NS-1:0] flush_state;
    logic          ctrl_busy;
`ifdef STALL_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [15:0]   perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: stall cycles still owed after the current one, and parked flush.
    int m_left = 0, m_left_n = 0;
    bit m_pend = 0, m_pend_n = 0;

    pipe_hazard_ctrl #(.NSTAGE(NS), .CNT_W(4), .BUSY_STAGE(BS), .FLUSH_STAGE(FS)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_req   (stall_req),
        .busy_start  (busy_start),
        .busy_len    (busy_len),
        .flush_req   (flush_req),
        .stall_state (stall_state),
        .flush_state (flush_state),
`ifdef STALL_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .ctrl_busy   (ctrl_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int  h;
        bit  busy_now, blocked, fire;
        int  es, ef, eb;
        if (rst) begin
            es = 0; ef = 0; eb = 0;
            m_left_n = 0;
            m_pend_n = 0;
        end else begin
            busy_now = (m_left > 0) || (busy_start && busy_len != 0);
            h = -1;
            for (int k = 0; k < NS; k++)
                if (stall_req[k] || (k == BS && busy_now)) h = k;
            es = (h < 0) ? 0 : (1 << (h + 1)) - 1;
            blocked = (h > FS) || (busy_now && BS >= FS);
            fire = (flush_req || m_pend) && !blocked;
            ef = 0;
            if (fire) begin
                ef = (1 << (FS + 1)) - 1;
                es = es & ~ef;
            end
            eb = (m_left > 0 || m_pend || (flush_req && blocked)) ? 1 : 0;
            if (fire && BS < FS)                      m_left_n = 0;
            else if (m_left > 0)                      m_left_n = m_left - 1;
            else if (busy_start && busy_len != 0)     m_left_n = int'(busy_len) - 1;
            else                                      m_left_n = 0;
            m_pend_n = fire ? 1'b0 : (m_pend | flush_req);
        end
        chk("model_stall_state", 32'(stall_state), 32'(es));
        chk("model_flush_state", 32'(flush_state), 32'(ef));
        chk("model_ctrl_busy",   32'(ctrl_busy),   32'(eb));
    end

    always @(posedge clk) begin
        m_left <= m_left_n;
        m_pend <= m_pend_n;
    end

    task automatic cyc(input logic [NS-1:0] sr, input logic bs, input logic [3:0] bl,
                       input logic fr, input logic r);
        @(posedge clk);
        #1;
        stall_req  = sr;
        busy_start = bs;
        busy_len   = bl;
        flush_req  = fr;
        rst        = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_req = '0; busy_start = 1'b0; busy_len = '0; flush_req = 1'b0;

        // Reset overrides all inputs
        cyc(5'b11111, 1, 4'd5, 1, 1);
        chk("rst_stall", 32'(stall_state), 32'h0);
        chk("rst_flush", 32'(flush_state), 32'h0);
        chk("rst_busy",  32'(ctrl_busy),   32'h0);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("idle_stall", 32'(stall_state), 32'h0);

        // Thermometer stall
        cyc(5'b01000, 0, 4'd0, 0, 0);
        chk("req3_stall", 32'(stall_state), 32'h0F);
        chk("req3_flush", 32'(flush_state), 32'h0);
        cyc(5'b00001, 0, 4'd0, 0, 0);
        chk("req0_stall", 32'(stall_state), 32'h01);
        cyc(5'b00110, 0, 4'd0, 0, 0);
        chk("req21_stall", 32'(stall_state), 32'h07);

        // Busy timer, length 3, re-start on cycle 1 ignored
        cyc(5'b00000, 1, 4'd3, 0, 0);
        chk("busy_c0_stall", 32'(stall_state), 32'h0F);
        chk("busy_c0_cb",    32'(ctrl_busy),   32'h0);
        cyc(5'b00000, 1, 4'd9, 0, 0);
        chk("busy_c1_stall", 32'(stall_state), 32'h0F);
        chk("busy_c1_cb",    32'(ctrl_busy),   32'h1);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("busy_c2_stall", 32'(stall_state), 32'h0F);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("busy_c3_stall", 32'(stall_state), 32'h00);
        chk("busy_c3_cb",    32'(ctrl_busy),   32'h0);
        cyc(5'b00000, 1, 4'd0, 0, 0);
        chk("busy_len0_stall", 32'(stall_state), 32'h00);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("busy_len0_next", 32'(stall_state), 32'h00);

        // Unblocked flush
        cyc(5'b00000, 0, 4'd0, 1, 0);
        chk("flush_c0_flush", 32'(flush_state), 32'h0F);
        chk("flush_c0_stall", 32'(stall_state), 32'h00);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("flush_c1_flush", 32'(flush_state), 32'h00);

        // Flush beats a younger stall
        cyc(5'b00100, 0, 4'd0, 1, 0);
        chk("flushwin_flush", 32'(flush_state), 32'h0F);
        chk("flushwin_stall", 32'(stall_state), 32'h00);

        // Flush blocked by older stall, repeated request merges
        cyc(5'b10000, 0, 4'd0, 1, 0);
        chk("fblk_c0_flush", 32'(flush_state), 32'h00);
        chk("fblk_c0_stall", 32'(stall_state), 32'h1F);
        chk("fblk_c0_cb",    32'(ctrl_busy),   32'h1);
        cyc(5'b10000, 0, 4'd0, 1, 0);
        chk("fblk_c1_flush", 32'(flush_state), 32'h00);
        chk("fblk_c1_cb",    32'(ctrl_busy),   32'h1);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("fblk_c2_flush", 32'(flush_state), 32'h0F);
        chk("fblk_c2_stall", 32'(stall_state), 32'h00);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("fblk_c3_flush", 32'(flush_state), 32'h00);
        chk("fblk_c3_cb",    32'(ctrl_busy),   32'h0);

        // Flush blocked by the busy timer at the flush stage
        cyc(5'b00000, 1, 4'd2, 1, 0);
        chk("fbusy_c0_flush", 32'(flush_state), 32'h00);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("fbusy_c1_flush", 32'(flush_state), 32'h00);
        chk("fbusy_c1_stall", 32'(stall_state), 32'h0F);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("fbusy_c2_flush", 32'(flush_state), 32'h0F);

        // Reset mid busy op
        cyc(5'b00000, 1, 4'd4, 0, 0);
        chk("rmid_c0_stall", 32'(stall_state), 32'h0F);
        cyc(5'b00000, 0, 4'd0, 0, 1);
        chk("rmid_c1_stall", 32'(stall_state), 32'h00);
        chk("rmid_c1_cb",    32'(ctrl_busy),   32'h0);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("rmid_c2_stall", 32'(stall_state), 32'h00);
        chk("rmid_c2_cb",    32'(ctrl_busy),   32'h0);

`ifdef STALL_PERF_EN
        cyc(5'b00000, 0, 4'd0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(5'b00001, 0, 4'd0, 0, 0);
        cyc(5'b00000, 0, 4'd0, 1, 0);
        chk("perf_stall_10", perf_stall_cnt, 32'd10);
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("perf_flush_1", 32'(perf_flush_cnt), 32'd1);
        @(posedge clk);
        #1;
        stall_req = 5'b00001;
        force dut.perf_stall_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.perf_stall_cnt_q;
        cyc(5'b00000, 0, 4'd0, 0, 0);
        chk("perf_stall_wrap", perf_stall_cnt, 32'd0);
`endif

        // Mixed traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [NS-1:0] sr;
            for (int k = 0; k < NS; k++) sr[k] = ($urandom_range(0, 7) == 0);
            cyc(sr, ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 6)),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 60) == 0));
        end

        cyc(5'b00000, 0, 4'd0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
